// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  localparam int unsigned DATA_W_DEF   = 64;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned NUM_RD_DEF   = 2;

  // Address of the hardwired zero register (the highest-numbered register).
  function automatic int unsigned zero_reg_addr(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, zero-register masking and an
// optional same-cycle write bypass (enabled by defining REGFILE_BYPASS_EN).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
  parameter int unsigned ADDR_W      = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic [NUM_REGS*DATA_W-1:0] mem_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic                       wr_fire_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic [DATA_W-1:0]          rd_data_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(zero_reg_addr(NUM_REGS));

  logic [DATA_W-1:0] arr_rd;
  logic              zero_hit;

  // Array mux; addresses with no matching register fall through to zero.
  always_comb begin
    arr_rd = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        arr_rd = mem_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign zero_hit = (ZERO_REG_EN != 0) && (rd_addr_i == ZERO_ADDR);

`ifdef REGFILE_BYPASS_EN
  // Write-then-read: forward a committing write; wr_fire_i already excludes
  // the zero register and out-of-range addresses.
  always_comb begin
    rd_data_o = arr_rd;
    if (zero_hit) begin
      rd_data_o = '0;
    end else if (wr_fire_i && (rd_addr_i == wr_addr_i)) begin
      rd_data_o = wr_data_i;
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{wr_fire_i, wr_addr_i, wr_data_i};

  // Read-then-write: the array value is returned until the edge.
  always_comb begin
    rd_data_o = arr_rd;
    if (zero_hit) begin
      rd_data_o = '0;
    end
  end
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with async reset, optional
// hardwired zero register and a one-register-per-cycle clear engine.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
  parameter int unsigned ADDR_W      = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD      = NUM_RD_DEF,
  parameter int unsigned ZERO_REG_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     wr_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(zero_reg_addr(NUM_REGS));

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  clr_state_t                      state_q;
  logic [ADDR_W-1:0]               idx_q;
  logic [ADDR_W-1:0]               idx_d;
  logic                            clr_busy_q;
  logic                            wr_ready_q;
  logic                            wr_addr_ok;
  logic                            wr_fire;

  assign clr_busy = clr_busy_q;
  assign wr_ready = wr_ready_q;

  // A write commits only to an in-range, non-hardwired register while ready.
  assign wr_addr_ok = (32'(wr_addr) < NUM_REGS) &&
                      !((ZERO_REG_EN != 0) && (wr_addr == ZERO_ADDR));
  assign wr_fire    = wr_en && wr_ready_q && wr_addr_ok;
  assign idx_d      = idx_q + ADDR_W'(1);

  // Clear engine: IDLE waits for a request, CLEAR walks idx 0..NUM_REGS-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_busy_q <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            clr_busy_q <= 1'b1;
            wr_ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
            wr_ready_q <= 1'b1;
          end else begin
            idx_q <= idx_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          idx_q      <= '0;
          clr_busy_q <= 1'b0;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage: clear walk zeroes one entry per cycle, otherwise the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if ((state_q == CLEAR) && (idx_q == ADDR_W'(i))) begin
          mem_q[i] <= '0;
        end else if (wr_fire && (wr_addr == ADDR_W'(i))) begin
          mem_q[i] <= wr_data;
        end
      end
    end
  end

  // One independent read port per rd_addr slice.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W      (DATA_W),
      .NUM_REGS    (NUM_REGS),
      .ADDR_W      (ADDR_W),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_rd_port (
      .mem_i     (mem_q),
      .rd_addr_i (rd_addr[p*ADDR_W +: ADDR_W]),
      .wr_fire_i (wr_fire),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the fixed 64-bit x 32-register, 2-read-port regfile in the pipelined CPU datapath.
- Generalised in data width, register count and read-port count.
- Adds an async reset to zero, a hardwired zero register, and a sequential clear engine that zeroes the array one register per cycle.
- Optional same-cycle write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 64, width of each register in bits.
- NUM_REGS, 32, number of architectural registers; must be ≥2.
- ADDR_W, $clog2(NUM_REGS), width of every register address.
- NUM_RD, 2, number of independent read ports; must be ≥1.
- ZERO_REG_EN, 1, when 1 register NUM_REGS-1 is hardwired to zero (X31/XZR).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- rd_addr  in  NUM_RD x ADDR_W  read address, one per port.
- rd_data  out  NUM_RD x DATA_W  read data, one per port.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  start the sequential clear; single-cycle pulse or level.
- clr_busy  out  1  high while the clear engine is running.
- wr_ready  out  1  equals !clr_busy; writes are accepted only when high.

Behaviour:
- Reset (async, any time, including mid-clear):
  - All registers become 0.
  - FSM returns to IDLE and the clear index to 0.
  - clr_busy=0, wr_ready=1; rd_data reflects zeros combinationally.
- Read:
  - Combinational, zero latency: rd_data[p] = mem[rd_addr[p]].
  - Addresses ≥ NUM_REGS (non-power-of-2 NUM_REGS) return 0.
  - When ZERO_REG_EN=1, reading address NUM_REGS-1 always returns 0.
- Write:
  - On the rising edge with wr_en & wr_ready: mem[wr_addr] <= wr_data.
  - The write is ignored if wr_addr ≥ NUM_REGS.
  - The write is ignored if ZERO_REG_EN=1 and wr_addr = NUM_REGS-1.
  - When wr_ready=0, wr_en is dropped, not queued; the upstream stage must stall.
- Clear FSM has two states, IDLE and CLEAR:
  - IDLE -> CLEAR on a clock edge with clr_req=1. The index is set to 0 and clr_busy=1 from the next cycle.
  - In CLEAR, each edge does mem[idx] <= 0 and idx <= idx+1.
  - CLEAR -> IDLE on the edge that clears idx = NUM_REGS-1. Total busy time is exactly NUM_REGS cycles.
  - clr_req while in CLEAR is ignored and does not restart the walk.
  - clr_req sampled in the same cycle the FSM returns to IDLE is not seen; a new request is needed.
  - Reads during CLEAR return current contents, so some registers read already-cleared and some not. Software must wait for clr_busy=0.
- Simultaneous events:
  - wr_en and clr_req in the same IDLE cycle: the write commits on that edge and CLEAR starts next cycle. The written value is later zeroed.
  - Read and write to the same address in the same cycle: behaviour is set by REGFILE_BYPASS_EN (see Optional Feature).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If wr_en & wr_ready, rd_addr[p] == wr_addr, and the address is writable, rd_data[p] = wr_data in that same cycle (write-then-read).
  - Applies independently per port.
  - Never applies to the zero register or to out-of-range addresses.
- Undefined:
  - rd_data[p] returns the old value until the edge (read-then-write), matching the previous regfile.

Decomposition:
- Package regfile_pkg:
  - clr_state_t enum {IDLE, CLEAR}.
  - Default parameter constants: DATA_W_DEF=64, NUM_REGS_DEF=32, NUM_RD_DEF=2.
  - Function zero_reg_addr(num_regs) returning num_regs-1.
- One sub-module: regfile_rd_port (one instance per read port via generate).
  - Handles the array mux, zero-register masking and optional bypass.
- Storage array, write decode and clear FSM live in the top module.

Test Plan:
- Reset then read: assert reset mid-run -> all NUM_RD ports read 0 for addresses 0..31 with no clock edge needed; clr_busy=0.
- Write/read: write 0x3E7 to r5 and 0x1 to r6, then read ports 0/1 at 5/6 -> 0x3E7/0x1 on the next cycle. Write 0xFFFF to r31 -> r31 still reads 0.
- Bypass: write 0xABCD to r7 while port 1 reads r7 in the same cycle.
  - With REGFILE_BYPASS_EN: port 1 shows 0xABCD that cycle.
  - Without it: port 1 shows the old value, then 0xABCD after the edge.
- Clear: preload r0..r30 with index+100, pulse clr_req.
  - clr_busy is high for exactly 32 cycles and wr_ready is low throughout.
  - A write of 0x55 to r3 attempted while busy is dropped.
  - Afterwards all registers read 0.
- Reset mid-clear: clr_req, then reset at busy cycle 10 -> immediately clr_busy=0 and all registers 0. A fresh clr_req takes a full 32 cycles.
- Parameter sweep: DATA_W=32, NUM_REGS=16, NUM_RD=4, ZERO_REG_EN=0 -> random writes/reads against a reference model for 2000 cycles. r15 is writable.
